// File: rtl/inst_fetch_seq_pkg.sv
// Shared control-bus definitions for the instruction fetch sequencer:
// the fetch FSM state enum, the bus-strobe record and its per-state decode.
package inst_fetch_seq_pkg;

  localparam int WAIT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    READ,
    LATCH,
    INC,
    WRITEBACK,
    DONE
  } fetch_state_t;

  typedef struct packed {
    logic sel_pc;
    logic mem_rd;
    logic ld_inst;
    logic ld_inc;
    logic sel_inc;
    logic ld_pc;
    logic fetch_done;
    logic busy;
  } ctrl_bus_t;

  // sel_pc and sel_inc are never set by the same state, so the address bus
  // has exactly one driver at a time.
  function automatic ctrl_bus_t decode_ctrl(input fetch_state_t s);
    ctrl_bus_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      ADDR:      begin c.sel_pc = 1'b1; c.ld_inc = 1'b1; end
      READ:      begin c.sel_pc = 1'b1; c.mem_rd = 1'b1; end
      LATCH:     begin c.sel_pc = 1'b1; c.mem_rd = 1'b1; c.ld_inst = 1'b1; end
      INC:       c.sel_inc = 1'b1;
      WRITEBACK: begin c.sel_inc = 1'b1; c.ld_pc = 1'b1; end
      DONE:      c.fetch_done = 1'b1;
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fetch_wait_ctr.sv
// Memory read wait counter: loads a wait count, counts down to zero and holds.
module fetch_wait_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/inst_fetch_seq.sv
// Instruction fetch sequencer: drives the PC/incrementer/memory strobes of one
// fetch cycle (ADDR, READ, LATCH, INC, WRITEBACK, DONE) back-to-back while run.
module inst_fetch_seq #(
  parameter int READ_WAIT = 2,
  parameter int N         = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         halt_req,
  input  logic         mem_ready,
  input  logic [N-1:0] data_in,
  output logic         sel_pc,
  output logic         mem_rd,
  output logic         ld_inst,
  output logic         ld_inc,
  output logic         sel_inc,
  output logic         ld_pc,
  output logic         fetch_done,
  output logic         busy,
  output logic         inst_zero
);

  import inst_fetch_seq_pkg::*;

  fetch_state_t state, next_state;
  ctrl_bus_t    ctrl_q;
  logic         armed;
  logic         wait_zero;

  // READ_WAIT must lie in 1..7 to fit the counter.
  fetch_wait_ctr #(.W(WAIT_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ADDR),
    .load_val (WAIT_W'(READ_WAIT)),
    .dec      (state == READ),
    .zero     (wait_zero)
  );

  // NOTE: every variable driven here gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (run && !halt_req && armed) next_state = ADDR;
      ADDR:      next_state = READ;
      READ:      if (wait_zero && mem_ready) next_state = LATCH;
      LATCH:     next_state = INC;
      INC:       next_state = WRITEBACK;
      WRITEBACK: next_state = DONE;
      DONE:      next_state = (run && !halt_req) ? ADDR : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Strobes are registered from the decode of next_state, so they change on
  // the same edge as state with no input-to-output combinational path.
  // armed holds off the first ADDR until the second edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctrl_q    <= '0;
      armed     <= 1'b0;
      inst_zero <= 1'b0;
    end else begin
      state  <= next_state;
      ctrl_q <= decode_ctrl(next_state);
      armed  <= 1'b1;
      if (state == LATCH) inst_zero <= (data_in == '0);
    end
  end

  assign sel_pc     = ctrl_q.sel_pc;
  assign mem_rd     = ctrl_q.mem_rd;
  assign ld_inst    = ctrl_q.ld_inst;
  assign ld_inc     = ctrl_q.ld_inc;
  assign sel_inc    = ctrl_q.sel_inc;
  assign ld_pc      = ctrl_q.ld_pc;
  assign fetch_done = ctrl_q.fetch_done;
  assign busy       = ctrl_q.busy;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Self-checking bench for inst_fetch_seq (READ_WAIT=2, N=8): vector table,
// scoreboard of per-fetch latency/ld_inst offset/inst_zero, and corner sequences.
module tb_inst_fetch_seq;

  localparam int RW = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, halt_req, mem_ready;
  logic [7:0] data_in;
  logic       sel_pc, mem_rd, ld_inst, ld_inc, sel_inc, ld_pc, fetch_done, busy, inst_zero;

  inst_fetch_seq #(.READ_WAIT(RW), .N(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .halt_req   (halt_req),
    .mem_ready  (mem_ready),
    .data_in    (data_in),
    .sel_pc     (sel_pc),
    .mem_rd     (mem_rd),
    .ld_inst    (ld_inst),
    .ld_inc     (ld_inc),
    .sel_inc    (sel_inc),
    .ld_pc      (ld_pc),
    .fetch_done (fetch_done),
    .busy       (busy),
    .inst_zero  (inst_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   lat;     // cycles from ADDR to fetch_done
    int   ld_off;  // cycles from ADDR to ld_inst
    logic zero;    // inst_zero seen at fetch_done
  } exp_t;

  typedef struct {
    logic [7:0] data;
    int         ready_low;  // READ cycles with mem_ready held low
    int         lat;
    int         ld_off;
    logic       zero;
  } vec_t;

  localparam int W_ADDR = 0;
  localparam int W_IDLE = 1;
  localparam int W_INC  = 2;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   addr_cyc = 0;
  int   inst_off = -1;
  int   ld_inst_cnt = 0;
  int   ld_pc_cnt = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] outs();
    return {sel_pc, mem_rd, ld_inst, ld_inc, sel_inc, ld_pc, fetch_done, busy, inst_zero};
  endfunction

  function automatic bit cond(input int which);
    case (which)
      W_ADDR:  return sel_pc && ld_inc;
      W_IDLE:  return !busy;
      default: return sel_inc && !ld_pc;
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, input string name);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = cond(which);
    end
    if (!hit) check(name, 0, 1);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        check("no_bus_contention", int'(sel_pc && sel_inc), 0);
        check("no_ldpc_with_selpc", int'(ld_pc && sel_pc), 0);
        if (sel_pc && ld_inc) addr_cyc = cyc;
        if (ld_inst) begin
          inst_off = cyc - addr_cyc;
          ld_inst_cnt++;
        end
        if (ld_pc) ld_pc_cnt++;
        if (fetch_done) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("fetch_latency", cyc - addr_cyc, e.lat);
            check("ld_inst_offset", inst_off, e.ld_off);
            check("inst_zero_at_done", int'(inst_zero), int'(e.zero));
          end
        end
      end
    end
  endtask

  vec_t vecs[7];
  int   n_addr;
  int   pc_before;

  initial begin
    rst_n = 1'b0; run = 1'b1; halt_req = 1'b0; mem_ready = 1'b1; data_in = 8'h5A;
    fork
      monitor();
    join_none

    // Reset state, then first ADDR only on the second edge after release.
    repeat (2) @(negedge clk);
    check("reset_outputs_zero", int'(outs()), 0);
    sb.push_back('{lat: 7, ld_off: 4, zero: 1'b0});
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_still_idle", int'(busy), 0);
    @(negedge clk);
    check("second_edge_addr", int'(sel_pc && ld_inc), 1);
    run = 1'b0;
    wait_for(W_IDLE, 40, "timeout_first_fetch");
    check("first_fetch_inst_zero", int'(inst_zero), 0);

    // Vector table; latency = 1 + max(RW+1, ready_low+1) + 3.
    vecs[0] = '{8'h5A, 0, 7, 4, 1'b0};
    vecs[1] = '{8'h00, 0, 7, 4, 1'b1};
    vecs[2] = '{8'h00, 2, 7, 4, 1'b1};
    vecs[3] = '{8'h3C, 4, 9, 6, 1'b0};
    vecs[4] = '{8'h80, 5, 10, 7, 1'b0};
    vecs[5] = '{8'h00, 1, 7, 4, 1'b1};
    vecs[6] = '{8'h01, 3, 8, 5, 1'b0};
    for (int i = 0; i < 7; i++) begin
      data_in   = vecs[i].data;
      mem_ready = (vecs[i].ready_low == 0);
      sb.push_back('{lat: vecs[i].lat, ld_off: vecs[i].ld_off, zero: vecs[i].zero});
      run = 1'b1;
      wait_for(W_ADDR, 20, "timeout_vec_addr");
      run = 1'b0;
      if (vecs[i].ready_low > 0) begin
        repeat (vecs[i].ready_low + 1) @(negedge clk);
        check("still_in_read", int'(mem_rd && !ld_inst), 1);
        mem_ready = 1'b1;
      end
      wait_for(W_IDLE, 40, "timeout_vec_idle");
      check("inst_zero_held_idle", int'(inst_zero), int'(vecs[i].zero));
    end

    // halt_req during READ: cycle completes, then no further ADDR.
    data_in = 8'h42; mem_ready = 1'b1; run = 1'b1;
    sb.push_back('{lat: 7, ld_off: 4, zero: 1'b0});
    wait_for(W_ADDR, 20, "timeout_halt_addr");
    @(negedge clk);
    halt_req = 1'b1;
    wait_for(W_IDLE, 40, "timeout_halt_idle");
    n_addr = 0;
    repeat (10) begin
      @(negedge clk);
      if (sel_pc && ld_inc) n_addr++;
      if (busy) n_addr++;
    end
    check("halt_no_restart", n_addr, 0);
    check("halt_fetch_completed", sb.size(), 0);
    halt_req = 1'b0; run = 1'b0;

    // Asynchronous reset during INC after a zero byte was latched.
    data_in = 8'h00; run = 1'b1;
    wait_for(W_ADDR, 20, "timeout_rst_addr");
    run = 1'b0;
    wait_for(W_INC, 20, "timeout_rst_inc");
    check("inst_zero_before_rst", int'(inst_zero), 1);
    pc_before = ld_pc_cnt;
    #1 rst_n = 1'b0;
    #1 check("async_reset_outputs", int'(outs()), 0);
    repeat (3) @(negedge clk);
    check("no_ld_pc_after_rst", ld_pc_cnt, pc_before);
    data_in = 8'h11; run = 1'b1;
    sb.push_back('{lat: 7, ld_off: 4, zero: 1'b0});
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_first_edge_idle", int'(busy), 0);
    @(negedge clk);
    check("restart_addr", int'(sel_pc && ld_inc), 1);
    run = 1'b0;
    wait_for(W_IDLE, 40, "timeout_restart_idle");
    check("restart_ld_pc", ld_pc_cnt, pc_before + 1);

    // 100 back-to-back fetches with random data, some zero bytes.
    ld_inst_cnt = 0; ld_pc_cnt = 0;
    mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wait_for(W_ADDR, 20, "timeout_run_addr");
      data_in = (i % 7 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      sb.push_back('{lat: 7, ld_off: 4, zero: (data_in == 8'h00)});
    end
    run = 1'b0;
    wait_for(W_IDLE, 40, "timeout_run_idle");
    check("ld_inst_count_100", ld_inst_cnt, 100);
    check("ld_pc_count_100", ld_pc_cnt, 100);
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
